// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / multdiv sequencer.
// Holds the core's opcode and ALU-op encodings, the sequencer FSM
// state type and the architectural status register index.
package pipe_hazard_ctrl_pkg;

  // Primary opcodes (instruction bits [31:27])
  localparam logic [4:0] OP_R    = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;

  // R-type ALU ops that go to the multi-cycle unit
  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  // Exceptions from multdiv are written to rstatus instead of rd
  localparam int RSTATUS_REG = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } md_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, clears count
//   en     - increment strobe
//   count  - current value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller and mult/div sequencer for the 5-stage core.
// Freezes FD/DX and the PC while a mult/div runs, issues its writeback,
// stalls on load-use hazards, flushes on taken branches and keeps
// saturating stall/flush counters.
// Ports:
//   clock, reset               - clock, async active-high reset
//   fd_rs/fd_rt/fd_uses_*      - source operands of the FD instruction
//   dx_is_load/dx_rd           - DX load flag and destination
//   md_start/md_is_div         - DX holds mult/div
//   md_rdy/md_exc              - multdiv ready (handshake mode) / exception
//   take_branch                - DX resolved a taken branch or jump
//   stall_pc/stall_fd          - hold PC / FD latch
//   bubble_dx/flush_fd         - nop into DX / squash FD
//   freeze_dx                  - hold DX latch
//   md_busy                    - sequencer in BUSY
//   md_wb_valid/md_wb_rd/_exc  - multdiv writeback strobe, dest, exception
//   stall_cnt/flush_cnt        - saturating performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int MULT_LAT     = 17,
  parameter int DIV_LAT      = 33,
  parameter int MD_HANDSHAKE = 0,
  parameter int CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] fd_rs,
  input  logic [REG_AW-1:0] fd_rt,
  input  logic              fd_uses_rs,
  input  logic              fd_uses_rt,
  input  logic              dx_is_load,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic              md_start,
  input  logic              md_is_div,
  input  logic              md_rdy,
  input  logic              md_exc,
  input  logic              take_branch,
  output logic              stall_pc,
  output logic              stall_fd,
  output logic              bubble_dx,
  output logic              flush_fd,
  output logic              freeze_dx,
  output logic              md_busy,
  output logic              md_wb_valid,
  output logic [REG_AW-1:0] md_wb_rd,
  output logic              md_wb_exc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 2);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 2);

  md_state_t         state, state_next;
  logic [CW-1:0]     count;
  logic [CW-1:0]     start_load;
  logic [REG_AW-1:0] md_rd_q;
  logic [REG_AW-1:0] wb_rd_src;
  logic              start_ok;
  logic              md_exit;
  logic              hazard;

  assign start_ok   = (state == IDLE) && md_start;
  assign start_load = md_is_div ? DIV_LOAD : MULT_LOAD;
  // A 2-cycle op skips BUSY entirely, so its dest comes straight from DX
  assign wb_rd_src  = (state == IDLE) ? dx_rd : md_rd_q;

  assign hazard = dx_is_load && (dx_rd != '0) &&
                  ((fd_uses_rs && (fd_rs == dx_rd)) ||
                   (fd_uses_rt && (fd_rt == dx_rd)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Loaded value is LAT-2: the start cycle and the WB cycle are not
  // BUSY cycles, so BUSY lasts exactly LAT-2 cycles and exits when the
  // count is about to reach zero.
  always_comb begin
    state_next = state;
    md_exit    = 1'b0;
    case (state)
      IDLE: begin
        if (md_start) begin
          if ((MD_HANDSHAKE == 0) && (start_load == '0)) begin
            state_next = WB;
            md_exit    = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (MD_HANDSHAKE != 0) begin
          if (md_rdy) begin
            state_next = WB;
            md_exit    = 1'b1;
          end
        end else if (count <= CW'(1)) begin
          state_next = WB;
          md_exit    = 1'b1;
        end
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      md_rd_q   <= '0;
      md_wb_rd  <= '0;
      md_wb_exc <= 1'b0;
    end else begin
      if (start_ok) begin
        md_rd_q <= dx_rd;
        count   <= start_load;
      end else if ((state == BUSY) && (count != '0)) begin
        count <= count - CW'(1);
      end
      if (md_exit) begin
        md_wb_exc <= md_exc;
        md_wb_rd  <= md_exc ? '0 : wb_rd_src;
      end
    end
  end

  // Freeze beats branch flush beats load-use stall. The start cycle
  // freezes too so the mult/div stays in DX. A branch squashes the
  // load consumer, so no PC stall is needed alongside it.
  always_comb begin
    stall_pc    = 1'b0;
    stall_fd    = 1'b0;
    bubble_dx   = 1'b0;
    flush_fd    = 1'b0;
    freeze_dx   = 1'b0;
    md_busy     = 1'b0;
    md_wb_valid = 1'b0;
    if (!reset) begin
      md_busy     = (state == BUSY);
      md_wb_valid = (state == WB);
      if ((state == BUSY) || start_ok) begin
        stall_pc  = 1'b1;
        stall_fd  = 1'b1;
        freeze_dx = 1'b1;
      end else if (take_branch) begin
        flush_fd  = 1'b1;
        bubble_dx = 1'b1;
      end else if (hazard) begin
        stall_pc  = 1'b1;
        stall_fd  = 1'b1;
        bubble_dx = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .en    (stall_pc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .en    (flush_fd),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Three instances share stimulus:
//   f - fixed latency (17/33), 32-bit counters
//   h - handshake mode
//   s - fixed latency, 10-cycle mult, 3-bit counters
// Inputs change just after the falling edge; outputs are checked 1 time
// unit later, well away from the rising edge.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] fd_rs = '0, fd_rt = '0, dx_rd = '0;
  logic       fd_uses_rs = 0, fd_uses_rt = 0, dx_is_load = 0;
  logic       md_start = 0, md_is_div = 0, md_rdy = 0, md_exc = 0;
  logic       take_branch = 0;

  logic        f_stall_pc, f_stall_fd, f_bubble_dx, f_flush_fd, f_freeze_dx;
  logic        f_md_busy, f_md_wb_valid, f_md_wb_exc;
  logic [4:0]  f_md_wb_rd;
  logic [31:0] f_stall_cnt, f_flush_cnt;

  logic        h_stall_pc, h_stall_fd, h_bubble_dx, h_flush_fd, h_freeze_dx;
  logic        h_md_busy, h_md_wb_valid, h_md_wb_exc;
  logic [4:0]  h_md_wb_rd;
  logic [31:0] h_stall_cnt, h_flush_cnt;

  logic        s_stall_pc, s_stall_fd, s_bubble_dx, s_flush_fd, s_freeze_dx;
  logic        s_md_busy, s_md_wb_valid, s_md_wb_exc;
  logic [4:0]  s_md_wb_rd;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int total  = 0;
  int passed = 0;
  int wb_seen;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.REG_AW(5), .MULT_LAT(17), .DIV_LAT(33),
                     .MD_HANDSHAKE(0), .CNT_W(32)) dut_f (
    .clock(clock), .reset(reset), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .md_start(md_start),
    .md_is_div(md_is_div), .md_rdy(md_rdy), .md_exc(md_exc),
    .take_branch(take_branch), .stall_pc(f_stall_pc), .stall_fd(f_stall_fd),
    .bubble_dx(f_bubble_dx), .flush_fd(f_flush_fd), .freeze_dx(f_freeze_dx),
    .md_busy(f_md_busy), .md_wb_valid(f_md_wb_valid), .md_wb_rd(f_md_wb_rd),
    .md_wb_exc(f_md_wb_exc), .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .MULT_LAT(17), .DIV_LAT(33),
                     .MD_HANDSHAKE(1), .CNT_W(32)) dut_h (
    .clock(clock), .reset(reset), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .md_start(md_start),
    .md_is_div(md_is_div), .md_rdy(md_rdy), .md_exc(md_exc),
    .take_branch(take_branch), .stall_pc(h_stall_pc), .stall_fd(h_stall_fd),
    .bubble_dx(h_bubble_dx), .flush_fd(h_flush_fd), .freeze_dx(h_freeze_dx),
    .md_busy(h_md_busy), .md_wb_valid(h_md_wb_valid), .md_wb_rd(h_md_wb_rd),
    .md_wb_exc(h_md_wb_exc), .stall_cnt(h_stall_cnt), .flush_cnt(h_flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .MULT_LAT(10), .DIV_LAT(33),
                     .MD_HANDSHAKE(0), .CNT_W(3)) dut_s (
    .clock(clock), .reset(reset), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .md_start(md_start),
    .md_is_div(md_is_div), .md_rdy(md_rdy), .md_exc(md_exc),
    .take_branch(take_branch), .stall_pc(s_stall_pc), .stall_fd(s_stall_fd),
    .bubble_dx(s_bubble_dx), .flush_fd(s_flush_fd), .freeze_dx(s_freeze_dx),
    .md_busy(s_md_busy), .md_wb_valid(s_md_wb_valid), .md_wb_rd(s_md_wb_rd),
    .md_wb_exc(s_md_wb_exc), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    fd_rs = '0; fd_rt = '0; dx_rd = '0;
    fd_uses_rs = 0; fd_uses_rt = 0; dx_is_load = 0;
    md_start = 0; md_is_div = 0; md_rdy = 0; md_exc = 0;
    take_branch = 0;
  endtask

  // Advance to the next falling edge where new inputs are applied
  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic apply_stimulus();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    clear_inputs();
    #2;
    check_output("rst_stall_pc", f_stall_pc, 0);
    check_output("rst_md_busy", f_md_busy, 0);
    check_output("rst_wb_valid", f_md_wb_valid, 0);
    check_output("rst_wb_rd", f_md_wb_rd, 0);
    check_output("rst_stall_cnt", f_stall_cnt, 0);
    check_output("rst_flush_cnt", f_flush_cnt, 0);

    // ---------------- fixed mode mult, rd=5 ----------------
    do_reset();
    // cycle 1: start
    md_start = 1; md_is_div = 0; dx_rd = 5'd5;
    apply_stimulus();
    check_output("fix_c1_stall_pc", f_stall_pc, 1);
    check_output("fix_c1_freeze", f_freeze_dx, 1);
    check_output("fix_c1_busy", f_md_busy, 0);
    check_output("fix_c1_bubble", f_bubble_dx, 0);
    // cycles 2..16: busy, mult stays frozen in DX
    for (int c = 2; c <= 16; c++) begin
      next_cycle();
      apply_stimulus();
      check_output($sformatf("fix_c%0d_busy", c), f_md_busy, 1);
      check_output($sformatf("fix_c%0d_stall_pc", c), f_stall_pc, 1);
      check_output($sformatf("fix_c%0d_wb_valid", c), f_md_wb_valid, 0);
    end
    // cycle 17: writeback, md_start still high but must not restart
    next_cycle();
    apply_stimulus();
    check_output("fix_c17_wb_valid", f_md_wb_valid, 1);
    check_output("fix_c17_wb_rd", f_md_wb_rd, 5);
    check_output("fix_c17_wb_exc", f_md_wb_exc, 0);
    check_output("fix_c17_stall_pc", f_stall_pc, 0);
    check_output("fix_c17_busy", f_md_busy, 0);
    // cycle 18: back in IDLE
    next_cycle();
    md_start = 0;
    apply_stimulus();
    check_output("fix_c18_wb_valid", f_md_wb_valid, 0);
    check_output("fix_c18_busy", f_md_busy, 0);
    check_output("fix_c18_stall_cnt", f_stall_cnt, 16);

    // ---------------- handshake div, rd=9, exception ----------------
    do_reset();
    md_start = 1; md_is_div = 1; dx_rd = 5'd9;
    apply_stimulus();
    check_output("hs_c1_stall_pc", h_stall_pc, 1);
    for (int c = 2; c <= 6; c++) begin
      next_cycle();
      if (c == 6) begin md_rdy = 1; md_exc = 1; end
      apply_stimulus();
      check_output($sformatf("hs_c%0d_busy", c), h_md_busy, 1);
      check_output($sformatf("hs_c%0d_wb_valid", c), h_md_wb_valid, 0);
    end
    next_cycle();
    md_rdy = 0; md_exc = 0;
    apply_stimulus();
    check_output("hs_c7_wb_valid", h_md_wb_valid, 1);
    check_output("hs_c7_wb_rd", h_md_wb_rd, 0);
    check_output("hs_c7_wb_exc", h_md_wb_exc, 1);
    check_output("hs_c7_stall_pc", h_stall_pc, 0);
    next_cycle();
    md_start = 0; md_is_div = 0;
    apply_stimulus();
    check_output("hs_c8_wb_valid", h_md_wb_valid, 0);
    check_output("hs_c8_stall_cnt", h_stall_cnt, 6);

    // ---------------- load-use ----------------
    do_reset();
    // cycle 1: lw r3 ; consumer reads r3 via rt
    dx_is_load = 1; dx_rd = 5'd3; fd_uses_rt = 1; fd_rt = 5'd3;
    apply_stimulus();
    check_output("lu_c1_stall_pc", f_stall_pc, 1);
    check_output("lu_c1_stall_fd", f_stall_fd, 1);
    check_output("lu_c1_bubble", f_bubble_dx, 1);
    check_output("lu_c1_freeze", f_freeze_dx, 0);
    check_output("lu_c1_flush", f_flush_fd, 0);
    // cycle 2: bubble now in DX
    next_cycle();
    dx_is_load = 0;
    apply_stimulus();
    check_output("lu_c2_stall_pc", f_stall_pc, 0);
    // cycle 3: match through rs
    next_cycle();
    dx_is_load = 1; dx_rd = 5'd7; fd_uses_rt = 0; fd_rt = 5'd0;
    fd_uses_rs = 1; fd_rs = 5'd7;
    apply_stimulus();
    check_output("lu_c3_rs_stall", f_stall_pc, 1);
    // cycle 4: same register but rs not read
    next_cycle();
    fd_uses_rs = 0;
    apply_stimulus();
    check_output("lu_c4_unused_rs", f_stall_pc, 0);
    // cycle 5: r0 never hazards
    next_cycle();
    dx_rd = 5'd0; fd_uses_rt = 1; fd_rt = 5'd0;
    apply_stimulus();
    check_output("lu_c5_r0_stall", f_stall_pc, 0);
    check_output("lu_c5_r0_bubble", f_bubble_dx, 0);
    // cycle 6: branch and load-use together
    next_cycle();
    dx_rd = 5'd3; fd_rt = 5'd3; take_branch = 1;
    apply_stimulus();
    check_output("lu_c6_stall_cnt", f_stall_cnt, 2);
    check_output("br_c6_flush", f_flush_fd, 1);
    check_output("br_c6_bubble", f_bubble_dx, 1);
    check_output("br_c6_stall_pc", f_stall_pc, 0);
    check_output("br_c6_stall_fd", f_stall_fd, 0);
    next_cycle();
    clear_inputs();
    apply_stimulus();
    check_output("br_c7_flush_cnt", f_flush_cnt, 1);
    check_output("br_c7_stall_cnt", f_stall_cnt, 2);
    check_output("br_c7_flush_off", f_flush_fd, 0);

    // ---------------- reset mid-BUSY div ----------------
    do_reset();
    md_start = 1; md_is_div = 1; dx_rd = 5'd12;
    apply_stimulus();
    for (int c = 2; c <= 8; c++) begin
      next_cycle();
      apply_stimulus();
      check_output($sformatf("ab_c%0d_busy", c), f_md_busy, 1);
    end
    #2;
    reset = 1'b1;
    md_start = 0; md_is_div = 0;
    #1;
    check_output("ab_rst_busy", f_md_busy, 0);
    check_output("ab_rst_stall_pc", f_stall_pc, 0);
    check_output("ab_rst_freeze", f_freeze_dx, 0);
    check_output("ab_rst_wb_valid", f_md_wb_valid, 0);
    check_output("ab_rst_wb_rd", f_md_wb_rd, 0);
    check_output("ab_rst_stall_cnt", f_stall_cnt, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    apply_stimulus();
    check_output("ab_rel_busy", f_md_busy, 0);
    wb_seen = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      apply_stimulus();
      if (f_md_wb_valid !== 1'b0) wb_seen++;
    end
    check_output("ab_no_wb", wb_seen, 0);

    // ---------------- saturation, 3-bit counter, 10-cycle mult ----------------
    do_reset();
    md_start = 1; md_is_div = 0; dx_rd = 5'd4;
    apply_stimulus();
    for (int c = 2; c <= 10; c++) begin
      next_cycle();
      apply_stimulus();
      if (c == 7) check_output("sat_c7_cnt", s_stall_cnt, 6);
      if (c == 8) check_output("sat_c8_cnt", s_stall_cnt, 7);
      if (c == 9) check_output("sat_c9_stall_pc", s_stall_pc, 1);
    end
    check_output("sat_c10_wb_valid", s_md_wb_valid, 1);
    check_output("sat_c10_wb_rd", s_md_wb_rd, 4);
    next_cycle();
    md_start = 0;
    apply_stimulus();
    check_output("sat_c11_cnt", s_stall_cnt, 7);
    check_output("sat_c11_wb_valid", s_md_wb_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and multi-cycle multiply/divide sequencer for the 5-stage core; sits beside the stage decoders and drives the PC/latch enables.
- Freezes the pipeline while a mult/div in DX is in flight (fixed-latency or ready-handshake mode) and issues its writeback.
- Detects load-use hazards and flushes FD/DX on taken branches/jumps.
- Keeps saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register address width
MULT_LAT, 17, mult cycles from start to result (fixed mode), >=2
DIV_LAT, 33, div cycles from start to result (fixed mode), >=2
MD_HANDSHAKE, 0, 0 = count fixed latency, 1 = wait for md_rdy
CNT_W, 32, perf counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
fd_rs  in  REG_AW  FD source reg A
fd_rt  in  REG_AW  FD source reg B
fd_uses_rs  in  1  FD instruction reads fd_rs
fd_uses_rt  in  1  FD instruction reads fd_rt
dx_is_load  in  1  DX holds lw
dx_rd  in  REG_AW  DX destination reg
md_start  in  1  DX holds mult or div (R-type, ALU op 6/7)
md_is_div  in  1  qualifies md_start: 1 = div
md_rdy  in  1  multdiv result ready (used only when MD_HANDSHAKE=1)
md_exc  in  1  multdiv exception (div by zero); sampled with md_rdy or terminal count
take_branch  in  1  DX resolved jump/taken branch (PC ctrl select)
stall_pc  out  1  hold PC
stall_fd  out  1  hold FD latch
bubble_dx  out  1  insert nop into DX next cycle
flush_fd  out  1  squash FD latch
freeze_dx  out  1  hold DX latch
md_busy  out  1  FSM in BUSY
md_wb_valid  out  1  one-cycle multdiv writeback strobe
md_wb_rd  out  REG_AW  writeback dest (0 when md_wb_exc)
md_wb_exc  out  1  exception; writeback goes to rstatus (r30) per setx convention
stall_cnt  out  CNT_W  saturating count of stall_pc cycles
flush_cnt  out  CNT_W  saturating count of flush_fd cycles

Behaviour:
- Reset (async, high): FSM=IDLE; counter=0; md_wb_rd=0; md_wb_exc=0; stall_cnt=0; flush_cnt=0. All combinational outputs are forced to 0 while reset is high.
- FSM states: IDLE, BUSY, WB.
- IDLE:
  - md_start=1: latch dx_rd to md_rd_q; load counter with (md_is_div ? DIV_LAT : MULT_LAT) - 2; go BUSY.
  - md_start is accepted only in IDLE.
- BUSY:
  - md_busy=1. stall_pc, stall_fd and freeze_dx are asserted; bubble_dx=0; flush_fd=0.
  - Fixed mode: decrement each cycle; at count 0, go WB.
  - Handshake mode: go WB in the cycle after md_rdy=1. Counter unused.
  - md_exc is captured into md_wb_exc on the exit cycle.
- WB (exactly one cycle):
  - md_wb_valid=1; md_wb_rd = md_wb_exc ? 0 : md_rd_q; all freezes released.
  - The DX mult/div advances, so it cannot restart. Always returns to IDLE.
- Fixed-mode latency: start cycle counts as cycle 1, so md_wb_valid is high on cycle MULT_LAT/DIV_LAT.
- Load-use (IDLE or WB only): hazard = dx_is_load & dx_rd != 0 & ((fd_uses_rs & fd_rs == dx_rd) | (fd_uses_rt & fd_rt == dx_rd)).
  - Asserts stall_pc, stall_fd, bubble_dx for exactly that cycle. After the bubble, the hazard clears naturally.
- Branch: take_branch=1 (outside BUSY) asserts flush_fd and bubble_dx.
- Priority: BUSY freeze > branch flush > load-use stall.
  - Simultaneous branch and load-use: flush only; stall_pc=0, because the consumer is squashed.
  - take_branch and md_start in the same cycle cannot occur; md_start wins if they do.
- Register 0 never produces a hazard. md_wb_rd=0 with md_wb_valid=1 is legal; the regfile ignores it.
- Counters increment by 1 on each cycle their strobe is high and saturate at all-ones; no wrap.
- Reset mid-BUSY: immediate return to IDLE; no md_wb_valid is ever emitted for the aborted op.

Decomposition:
- Shared package holds:
  - opcode constants: R=0, J=1, BNE=2, JAL=3, JR=4, ADDI=5, BLT=6, SW=7, LW=8, SETX=21, BEX=22.
  - ALU op constants: MUL=6, DIV=7.
  - FSM state enum {IDLE, BUSY, WB}.
  - RSTATUS_REG=30.
- Sub-module: sat_counter (width-parameterised saturating incrementer), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Fixed mode, mult to rd=5: pulse md_start, md_is_div=0 -> md_busy high for cycles 2..16; stall_pc/freeze_dx high on cycles 1..16; md_wb_valid=1, md_wb_rd=5 on cycle 17 only.
- Handshake mode, div to rd=9: md_rdy on cycle 6 with md_exc=1 -> md_wb_valid on cycle 7 with md_wb_rd=0, md_wb_exc=1; stall_cnt increments by 6.
- Load-use: dx_is_load=1, dx_rd=3, fd_uses_rt=1, fd_rt=3 -> one cycle of stall_pc=stall_fd=bubble_dx=1. With dx_rd=0 -> no stall.
- Branch and load-use in the same cycle -> flush_fd=1, bubble_dx=1, stall_pc=0; flush_cnt=1, stall_cnt unchanged.
- Reset asserted at cycle 8 of a DIV_LAT=33 op -> all outputs 0 asynchronously; FSM IDLE after release; no md_wb_valid ever.
- CNT_W=3 with a 10-cycle mult -> stall_cnt saturates at 7 and holds.
